// File: rtl/exfifo_byte_bridge_if.sv
// Host byte streams and CPU word FIFO ports of the byte bridge.
interface exfifo_byte_bridge_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   exfifo_if_d;
  logic          exfifo_if_rd;
  logic          exfifo_if_rdempty;
  logic [31:0]   exfifo_of_d;
  logic          exfifo_of_wr;
  logic          exfifo_of_wrfull;
  logic          exfifo_rst;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] if_level;
  logic [LW-1:0] of_level;
  logic          of_overflow;

  modport slave (
    input  in_data, in_valid, exfifo_if_rd, exfifo_of_d, exfifo_of_wr,
           exfifo_rst, out_ready,
    output in_ready, exfifo_if_d, exfifo_if_rdempty, exfifo_of_wrfull,
           out_data, out_valid, if_level, of_level, of_overflow
  );

  modport master (
    output in_data, in_valid, exfifo_if_rd, exfifo_of_d, exfifo_of_wr,
           exfifo_rst, out_ready,
    input  in_ready, exfifo_if_d, exfifo_if_rdempty, exfifo_of_wrfull,
           out_data, out_valid, if_level, of_level, of_overflow
  );
endinterface

// File: rtl/exfifo_byte_bridge.sv
// Byte-to-word bridge: packs host bytes into an ingress word FIFO for the CPU,
// and unpacks CPU words from an egress FIFO into host bytes (LSB first).
module exfifo_byte_bridge #(
  parameter int unsigned DEPTH = 16
) (
  input logic                  clk,
  input logic                  reset_n,
  exfifo_byte_bridge_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  // Ingress side
  logic [1:0]    pcnt;
  logic [23:0]   pword;
  logic [31:0]   if_mem [DEPTH];
  logic [AW-1:0] if_wr_ptr;
  logic [AW-1:0] if_rd_ptr;
  logic [LW-1:0] if_cnt;
  logic          if_empty;
  logic          if_full;
  logic          in_ready;
  logic          in_acc;
  logic          if_push;
  logic          if_pop;

  // Egress side
  logic [1:0]    sel;
  logic [31:0]   of_mem [DEPTH];
  logic [AW-1:0] of_wr_ptr;
  logic [AW-1:0] of_rd_ptr;
  logic [LW-1:0] of_cnt;
  logic          of_empty;
  logic          of_full;
  logic          of_xfer;
  logic          of_pop;
  logic          of_push;
  logic          of_drop;
  logic          ovf;
  logic [31:0]   of_head;
  logic [7:0]    out_byte;

  assign if_empty = (if_cnt == '0);
  assign if_full  = (if_cnt == FULL_LVL);
  assign of_empty = (of_cnt == '0);
  assign of_full  = (of_cnt == FULL_LVL);

  // No read-bypass: byte 3 waits for a free slot even if the CPU pops this cycle
  assign in_ready = !bus.exfifo_rst && ((pcnt != 2'd3) || !if_full);
  assign in_acc   = bus.in_valid && in_ready;
  assign if_push  = in_acc && (pcnt == 2'd3);
  assign if_pop   = bus.exfifo_if_rd && !if_empty && !bus.exfifo_rst;

  // A pop of the last byte of a full FIFO frees the slot a same-cycle write uses
  assign of_xfer  = !of_empty && bus.out_ready && !bus.exfifo_rst;
  assign of_pop   = of_xfer && (sel == 2'd3);
  assign of_push  = bus.exfifo_of_wr && !bus.exfifo_rst && (!of_full || of_pop);
  assign of_drop  = bus.exfifo_of_wr && !bus.exfifo_rst && of_full && !of_pop;

  assign of_head  = of_mem[of_rd_ptr];

  // Select the current byte lane of the egress head word
  always_comb begin
    out_byte = 8'd0;
    case (sel)
      2'd0:    out_byte = of_head[7:0];
      2'd1:    out_byte = of_head[15:8];
      2'd2:    out_byte = of_head[23:16];
      default: out_byte = of_head[31:24];
    endcase
  end

  assign bus.in_ready          = in_ready;
  assign bus.exfifo_if_rdempty = if_empty;
  assign bus.exfifo_if_d       = if_empty ? 32'd0 : if_mem[if_rd_ptr];
  assign bus.exfifo_of_wrfull  = of_full;
  assign bus.out_valid         = !of_empty;
  assign bus.out_data          = of_empty ? 8'd0 : out_byte;
  assign bus.if_level          = if_cnt;
  assign bus.of_level          = of_cnt;
  assign bus.of_overflow       = ovf;

  // Word storage; contents are never visible while the FIFO is empty
  always_ff @(posedge clk) begin
    if (if_push) begin
      if_mem[if_wr_ptr] <= {bus.in_data, pword};
    end
    if (of_push) begin
      of_mem[of_wr_ptr] <= bus.exfifo_of_d;
    end
  end

  // Packer and ingress FIFO pointers/count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt      <= 2'd0;
      pword     <= 24'd0;
      if_wr_ptr <= '0;
      if_rd_ptr <= '0;
      if_cnt    <= '0;
    end else if (bus.exfifo_rst) begin
      pcnt      <= 2'd0;
      pword     <= 24'd0;
      if_wr_ptr <= '0;
      if_rd_ptr <= '0;
      if_cnt    <= '0;
    end else begin
      if (in_acc) begin
        case (pcnt)
          2'd0:    pword[7:0]   <= bus.in_data;
          2'd1:    pword[15:8]  <= bus.in_data;
          2'd2:    pword[23:16] <= bus.in_data;
          default: ;
        endcase
        pcnt <= pcnt + 2'd1;
      end
      if (if_push) begin
        if_wr_ptr <= if_wr_ptr + AW'(1);
      end
      if (if_pop) begin
        if_rd_ptr <= if_rd_ptr + AW'(1);
      end
      if_cnt <= if_cnt + LW'(if_push) - LW'(if_pop);
    end
  end

  // Unpacker and egress FIFO pointers/count, sticky overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel       <= 2'd0;
      of_wr_ptr <= '0;
      of_rd_ptr <= '0;
      of_cnt    <= '0;
      ovf       <= 1'b0;
    end else if (bus.exfifo_rst) begin
      sel       <= 2'd0;
      of_wr_ptr <= '0;
      of_rd_ptr <= '0;
      of_cnt    <= '0;
      ovf       <= 1'b0;
    end else begin
      if (of_xfer) begin
        sel <= sel + 2'd1;
      end
      if (of_push) begin
        of_wr_ptr <= of_wr_ptr + AW'(1);
      end
      if (of_pop) begin
        of_rd_ptr <= of_rd_ptr + AW'(1);
      end
      if (of_drop) begin
        ovf <= 1'b1;
      end
      of_cnt <= of_cnt + LW'(of_push) - LW'(of_pop);
    end
  end
endmodule

// File: doc/exfifo_byte_bridge.md
EXFIFO_BYTE_BRIDGE -- requirements
Module: exfifo_byte_bridge

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the word depth of each internal FIFO (power of two, 4..64).
REQ-002 The block SHALL have port clk  input  1  system clock; all logic rising-edge.
REQ-003 The block SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port in_data  input  8  host ingress byte.
REQ-005 The block SHALL have port in_valid  input  1  in_data valid.
REQ-006 The block SHALL have port in_ready  output  1  byte accepted when in_valid and in_ready are both high.
REQ-007 The block SHALL have port exfifo_if_d  output  32  head word of the ingress FIFO (show-ahead).
REQ-008 The block SHALL have port exfifo_if_rd  input  1  CPU pop of the ingress head word.
REQ-009 The block SHALL have port exfifo_if_rdempty  output  1  ingress FIFO empty.
REQ-010 The block SHALL have port exfifo_of_d  input  32  CPU egress word.
REQ-011 The block SHALL have port exfifo_of_wr  input  1  CPU write strobe for exfifo_of_d.
REQ-012 The block SHALL have port exfifo_of_wrfull  output  1  egress FIFO full.
REQ-013 The block SHALL have port exfifo_rst  input  1  synchronous clear from the CPU.
REQ-014 The block SHALL have port out_data  output  8  host egress byte.
REQ-015 The block SHALL have port out_valid  output  1  out_data valid.
REQ-016 The block SHALL have port out_ready  input  1  host accepts out_data.
REQ-017 The block SHALL have port if_level  output  log2(DEPTH)+1  ingress FIFO word count.
REQ-018 The block SHALL have port of_level  output  log2(DEPTH)+1  egress FIFO word count.
REQ-019 The block SHALL have port of_overflow  output  1  sticky flag: exfifo_of_wr occurred while full.

Function
REQ-020 Packer SHALL hold a 2-bit byte counter; accepted bytes fill the word LSB first (byte 0 -> bits 7:0, byte 3 -> bits 31:24).
REQ-021 in_ready SHALL be 1 when byte counter < 3, and when byte counter = 3 only if the ingress FIFO is not full; no read-bypass of a full FIFO.
REQ-022 Accepting byte 3 SHALL write the completed word into the ingress FIFO on the same edge; it is visible on exfifo_if_d / exfifo_if_rdempty=0 the following cycle.
REQ-023 exfifo_if_d SHALL present the head word whenever exfifo_if_rdempty=0; exfifo_if_rd pops it on that edge; exfifo_if_rd while empty SHALL be ignored.
REQ-024 Simultaneous ingress push and pop SHALL leave if_level unchanged and preserve order.
REQ-025 exfifo_of_wr with exfifo_of_wrfull=0 SHALL push exfifo_of_d; with exfifo_of_wrfull=1 the word SHALL be dropped and of_overflow set.
REQ-026 exfifo_of_wrfull SHALL equal (of_level = DEPTH); exfifo_if_rdempty SHALL equal (if_level = 0); both combinational from registered counts.
REQ-027 Unpacker SHALL hold a 2-bit byte select; out_valid = egress FIFO not empty; out_data = head word bits [8*sel+7 : 8*sel].
REQ-028 On out_valid and out_ready, sel SHALL increment; when sel = 3 the head word SHALL be popped and sel wraps to 0.
REQ-029 Egress push and pop in the same cycle SHALL leave of_level unchanged, including at full (pop frees the slot the push occupies).
REQ-030 Pointers SHALL wrap modulo DEPTH; counts span 0..DEPTH inclusive.
REQ-031 exfifo_rst=1 SHALL, on that edge, empty both FIFOs, zero both byte counters and clear of_overflow, overriding all same-cycle push/pop/byte transfers; a partial packer word is discarded.
REQ-032 While exfifo_rst=1, in_ready SHALL be 0 and exfifo_if_rd / exfifo_of_wr SHALL be ignored.

Reset
REQ-033 reset_n=0 SHALL asynchronously force: FIFOs empty, counters 0, of_overflow=0, in_ready=1, exfifo_if_rdempty=1, exfifo_of_wrfull=0, out_valid=0, if_level=of_level=0, exfifo_if_d=0, out_data=0.
REQ-034 Reset deassertion mid-operation SHALL resume from the empty state; FIFO RAM contents are don't-care and never visible while empty.

Verification
REQ-035 Bytes 0x11,0x22,0x33,0x44 pushed -> next cycle exfifo_if_rdempty=0, exfifo_if_d=0x44332211, if_level=1; one exfifo_if_rd -> rdempty=1.
REQ-036 4*DEPTH bytes pushed with no reads -> if_level=DEPTH, in_ready=0 at byte counter 3; one exfifo_if_rd -> next byte 3 accepted, level stays DEPTH.
REQ-037 exfifo_of_wr 0xA1B2C3D4 with out_ready=1 -> out_data 0xD4,0xC3,0xB2,0xA1 on four consecutive cycles, then out_valid=0.
REQ-038 DEPTH+1 exfifo_of_wr with out_ready=0 -> wrfull=1 after DEPTH, last word dropped, of_overflow=1; first output byte from word 0.
REQ-039 Two bytes pushed, then exfifo_rst with simultaneous of_wr and if_rd -> all levels 0, overflow 0; next 4 bytes form a word from byte 0.
REQ-040 reset_n pulsed low mid-transfer (FIFOs half full) -> all outputs at REQ-033 values immediately, without a clock edge.
